eth_gmii_tx: RTL and testbench
==============================

ETH_GMII_TX -- requirements
Module: eth_gmii_tx

Interface
REQ-001 Parameter IFG_BYTES, default 12, idle byte-times between frames.
REQ-002 Parameter MIN_PAYLOAD, default 60, minimum frame bytes before FCS (DA..payload).
REQ-003 clk  in  1  single clock; all logic on rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 i_tx_data  in  32  frame word; byte order [31:24] first on wire.
REQ-006 i_tx_vld  in  1  word valid.
REQ-007 i_tx_sop  in  1  first word of frame (first DA bytes).
REQ-008 i_tx_eop  in  1  last word of frame.
REQ-009 i_tx_mod  in  2  count of invalid trailing bytes in eop word (0 = all 4 valid); ignored when eop=0.
REQ-010 o_tx_rdy  out  1  word accepted on cycle with i_tx_vld & o_tx_rdy.
REQ-011 o_gmii_txd  out  8  GMII transmit byte.
REQ-012 o_gmii_txen  out  1  GMII transmit enable.
REQ-013 o_gmii_txer  out  1  GMII transmit error.
REQ-014 o_busy  out  1  high in every state except IDLE.
REQ-015 o_frame_cnt  out  16  frames completed without error, wraps 0xFFFF->0.
REQ-016 o_err_cnt  out  8  underruns + orphan words, saturates at 255.

Function
REQ-017 States SHALL be IDLE, PRE, SFD, DATA, PAD, FCS, IFG, DROP.
REQ-018 IDLE: o_tx_rdy=1; accepted word with sop=1 latched into word register, next state PRE; accepted word with sop=0 discarded, o_err_cnt+1.
REQ-019 PRE: 7 cycles txd=0x55, txen=1; SFD: 1 cycle txd=0xD5; first data byte on 9th cycle after sop acceptance (txen rises 1 cycle after acceptance).
REQ-020 DATA: one byte per cycle from word register, [31:24] first; o_tx_rdy=1 only on cycle driving last byte of a non-eop word.
REQ-021 In DATA, next word SHALL be accepted in that same cycle so bytes stream back-to-back with no gap.
REQ-022 Underrun: i_tx_vld=0 when word required -> txer=1 with txen=1 for one cycle, then DROP; frame not counted; o_err_cnt+1.
REQ-023 DROP: txen=0, o_tx_rdy=1, discard words until accepted eop, then IFG; sop seen in DROP SHALL also be discarded.
REQ-024 eop word: only 4-i_tx_mod bytes transmitted; then PAD if byte count < MIN_PAYLOAD, else FCS.
REQ-025 PAD: txd=0x00 until byte count = MIN_PAYLOAD; pad bytes included in CRC.
REQ-026 Byte counter 11 bits, saturating at 2047; frames longer than 2047 bytes transmitted unmodified.
REQ-027 CRC-32 (poly 0x04C11DB7 reflected, init 0xFFFFFFFF) over DA through last pad byte; FCS = ~crc sent low byte first, 4 cycles.
REQ-028 IFG: txen=0, txd=0x00, o_tx_rdy=0 for exactly IFG_BYTES cycles, then IDLE; o_frame_cnt+1 on FCS->IFG if no error.
REQ-029 Outside PRE/SFD/DATA/PAD/FCS: txen=0, txer=0, txd=0x00.
REQ-030 txer SHALL never assert except the underrun cycle.

Reset
REQ-031 rst high: state IDLE, o_gmii_txd=0x00, txen=0, txer=0, o_tx_rdy=0 during reset, o_busy=0, counters 0, CRC=0xFFFFFFFF.
REQ-032 rst mid-frame: txen drops on next cycle, no FCS emitted, frame not counted; o_tx_rdy=1 first cycle after rst release.

Structure
REQ-033 Shared package holds state encoding, preamble/SFD constants, CRC polynomial and init value.
REQ-034 Single sub-module eth_crc32_d8: 8-bit-per-cycle CRC update with init/enable inputs.

Verification
REQ-035 eth_crc32_d8 over ASCII "123456789" -> ~crc = 0xCBF43926.
REQ-036 Sop at cycle 0, 16 words, mod=0 -> txen rises cycle 1, 0xD5 at cycle 8, 64 data bytes from cycle 9, FCS matches model, 12 idle cycles, o_frame_cnt=1.
REQ-037 3-word frame, eop mod=2 (10 bytes) -> 10 data + 50 0x00 pad + 4 FCS bytes; txen high 72 cycles.
REQ-038 vld dropped after word 5 of 16 -> single txer cycle after byte 20, txen low, remaining words consumed to eop, o_err_cnt=1, o_frame_cnt unchanged.
REQ-039 Non-sop word in IDLE -> o_tx_rdy=1, word dropped, o_err_cnt=1, txen stays 0; 300 such words -> o_err_cnt=255.
REQ-040 rst asserted mid-DATA -> txen=0 next cycle, all outputs at reset values; following frame transmits correctly.

Source files
------------

// File: rtl/eth_gmii_tx_pkg.sv
// Shared definitions for the GMII frame transmitter: FSM encoding, preamble/SFD
// bytes, the CRC-32 polynomial and seed, and a byte-wide CRC step.
package eth_gmii_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRE,
    ST_SFD,
    ST_DATA,
    ST_PAD,
    ST_FCS,
    ST_IFG,
    ST_DROP
  } state_e;

  localparam logic [7:0]  PRE_BYTE   = 8'h55;
  localparam logic [7:0]  SFD_BYTE   = 8'hD5;
  localparam int          PRE_LEN    = 7;
  localparam int          BYTE_CNT_W = 11;
  localparam logic [31:0] CRC_POLY   = 32'h04C11DB7;
  localparam logic [31:0] CRC_INIT   = 32'hFFFFFFFF;

  function automatic logic [31:0] reflect32(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = v[31-i];
    return r;
  endfunction

  // Ethernet shifts LSB first, so the update runs on the bit-reversed polynomial.
  localparam logic [31:0] CRC_POLY_REFL = reflect32(CRC_POLY);

  function automatic logic [31:0] crc32_update8(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    c = crc ^ {24'h0, data};
    for (int i = 0; i < 8; i++) c = c[0] ? ((c >> 1) ^ CRC_POLY_REFL) : (c >> 1);
    return c;
  endfunction

endpackage

// File: rtl/eth_gmii_tx_if.sv
// Word-wide frame stream into the GMII transmitter (valid/ready handshake).
interface eth_gmii_tx_if;
  logic [31:0] tx_data;
  logic        tx_vld;
  logic        tx_sop;
  logic        tx_eop;
  logic [1:0]  tx_mod;
  logic        tx_rdy;

  modport master (output tx_data, tx_vld, tx_sop, tx_eop, tx_mod, input tx_rdy);
  modport slave  (input tx_data, tx_vld, tx_sop, tx_eop, tx_mod, output tx_rdy);
endinterface

// File: rtl/eth_crc32_d8.sv
// Ethernet CRC-32 register advancing one byte per enabled cycle.
module eth_crc32_d8
  import eth_gmii_tx_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        init,
  input  logic        en,
  input  logic [7:0]  data,
  output logic [31:0] crc
);

  logic [31:0] crc_q, crc_d;

  always_comb begin
    crc_d = crc_q;
    if (init)    crc_d = CRC_INIT;
    else if (en) crc_d = crc32_update8(crc_q, data);
  end

  // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) crc_q <= CRC_INIT;
    else     crc_q <= crc_d;
  end

  assign crc = crc_q;

endmodule

// File: rtl/eth_gmii_tx.sv
// GMII transmitter: frames 32-bit words with preamble/SFD, pads short frames,
// appends the FCS and enforces the inter-frame gap.
module eth_gmii_tx
  import eth_gmii_tx_pkg::*;
#(
  parameter int IFG_BYTES   = 12,
  parameter int MIN_PAYLOAD = 60
) (
  input  logic          clk,
  input  logic          rst,
  eth_gmii_tx_if.slave  tx,
  output logic [7:0]    o_gmii_txd,
  output logic          o_gmii_txen,
  output logic          o_gmii_txer,
  output logic          o_busy,
  output logic [15:0]   o_frame_cnt,
  output logic [7:0]    o_err_cnt
);

  localparam logic [BYTE_CNT_W-1:0] BYTE_MAX = '1;
  localparam logic [BYTE_CNT_W-1:0] MIN_LEN  = BYTE_CNT_W'(MIN_PAYLOAD);
  localparam logic [15:0]           IFG_LAST = 16'(IFG_BYTES - 1);
  localparam logic [15:0]           PRE_LAST = 16'(PRE_LEN - 1);

  state_e                 state_q, state_d;
  logic [31:0]            word_q, word_d;
  logic                   eop_q, eop_d;
  logic [1:0]             mod_q, mod_d;
  logic [15:0]            idx_q, idx_d;
  logic [BYTE_CNT_W-1:0]  byte_cnt_q, byte_cnt_d;
  logic                   underrun_q, underrun_d;
  logic [15:0]            frame_cnt_q, frame_cnt_d;
  logic [7:0]             err_cnt_q, err_cnt_d;

  logic                   rdy, crc_init, crc_en;
  logic [7:0]             crc_byte, cur_byte, err_inc;
  logic [31:0]            crc;
  logic [BYTE_CNT_W-1:0]  byte_cnt_inc;
  logic [1:0]             last_sel;

  eth_crc32_d8 u_crc (
    .clk  (clk),
    .rst  (rst),
    .init (crc_init),
    .en   (crc_en),
    .data (crc_byte),
    .crc  (crc)
  );

  assign byte_cnt_inc = (byte_cnt_q == BYTE_MAX) ? BYTE_MAX : byte_cnt_q + 1'b1;
  assign err_inc      = (err_cnt_q == 8'hFF) ? 8'hFF : err_cnt_q + 8'd1;
  assign last_sel     = eop_q ? 2'd3 - mod_q : 2'd3;
  assign cur_byte     = 8'(word_q >> {2'd3 - idx_q[1:0], 3'b000});

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    word_d      = word_q;
    eop_d       = eop_q;
    mod_d       = mod_q;
    idx_d       = idx_q;
    byte_cnt_d  = byte_cnt_q;
    underrun_d  = 1'b0;
    frame_cnt_d = frame_cnt_q;
    err_cnt_d   = err_cnt_q;
    rdy         = 1'b0;
    crc_init    = 1'b0;
    crc_en      = 1'b0;
    crc_byte    = 8'h00;
    o_gmii_txd  = 8'h00;
    o_gmii_txen = 1'b0;
    o_gmii_txer = 1'b0;

    case (state_q)
      ST_IDLE: begin
        rdy = 1'b1;
        if (tx.tx_vld) begin
          if (tx.tx_sop) begin
            word_d     = tx.tx_data;
            eop_d      = tx.tx_eop;
            mod_d      = tx.tx_mod;
            idx_d      = '0;
            byte_cnt_d = '0;
            crc_init   = 1'b1;
            state_d    = ST_PRE;
          end else begin
            err_cnt_d = err_inc;
          end
        end
      end
      ST_PRE: begin
        o_gmii_txen = 1'b1;
        o_gmii_txd  = PRE_BYTE;
        idx_d       = idx_q + 16'd1;
        if (idx_q == PRE_LAST) state_d = ST_SFD;
      end
      ST_SFD: begin
        o_gmii_txen = 1'b1;
        o_gmii_txd  = SFD_BYTE;
        idx_d       = '0;
        state_d     = ST_DATA;
      end
      ST_DATA: begin
        o_gmii_txen = 1'b1;
        if (underrun_q) begin
          // Single poisoned byte-time so the link partner discards the frame.
          o_gmii_txer = 1'b1;
          state_d     = ST_DROP;
        end else begin
          o_gmii_txd = cur_byte;
          crc_en     = 1'b1;
          crc_byte   = cur_byte;
          byte_cnt_d = byte_cnt_inc;
          idx_d      = idx_q + 16'd1;
          if (idx_q[1:0] == last_sel) begin
            idx_d = '0;
            if (eop_q) begin
              state_d = (byte_cnt_inc < MIN_LEN) ? ST_PAD : ST_FCS;
            end else begin
              // Fetch the next word while its predecessor's last byte is on the wire.
              rdy = 1'b1;
              if (tx.tx_vld) begin
                word_d = tx.tx_data;
                eop_d  = tx.tx_eop;
                mod_d  = tx.tx_mod;
              end else begin
                underrun_d = 1'b1;
                err_cnt_d  = err_inc;
              end
            end
          end
        end
      end
      ST_PAD: begin
        o_gmii_txen = 1'b1;
        crc_en      = 1'b1;
        byte_cnt_d  = byte_cnt_inc;
        if (byte_cnt_inc >= MIN_LEN) begin
          idx_d   = '0;
          state_d = ST_FCS;
        end
      end
      ST_FCS: begin
        o_gmii_txen = 1'b1;
        o_gmii_txd  = 8'((~crc) >> {idx_q[1:0], 3'b000});
        idx_d       = idx_q + 16'd1;
        if (idx_q[1:0] == 2'd3) begin
          idx_d       = '0;
          frame_cnt_d = frame_cnt_q + 16'd1;
          state_d     = ST_IFG;
        end
      end
      ST_IFG: begin
        idx_d = idx_q + 16'd1;
        if (idx_q == IFG_LAST) begin
          idx_d   = '0;
          state_d = ST_IDLE;
        end
      end
      ST_DROP: begin
        rdy = 1'b1;
        if (tx.tx_vld && tx.tx_eop) begin
          idx_d   = '0;
          state_d = ST_IFG;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      word_q      <= '0;
      eop_q       <= 1'b0;
      mod_q       <= '0;
      idx_q       <= '0;
      byte_cnt_q  <= '0;
      underrun_q  <= 1'b0;
      frame_cnt_q <= '0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      word_q      <= word_d;
      eop_q       <= eop_d;
      mod_q       <= mod_d;
      idx_q       <= idx_d;
      byte_cnt_q  <= byte_cnt_d;
      underrun_q  <= underrun_d;
      frame_cnt_q <= frame_cnt_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign tx.tx_rdy   = rdy & ~rst;
  assign o_busy      = (state_q != ST_IDLE);
  assign o_frame_cnt = frame_cnt_q;
  assign o_err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_eth_gmii_tx.sv
// Directed bench for eth_gmii_tx and its CRC sub-module; expected bytes come from
// an independent bit-serial CRC model and hand-derived frame timing.
module tb_eth_gmii_tx;

  localparam int IFG  = 12;
  localparam int MINP = 60;

  typedef logic [7:0] bq_t[$];

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  eth_gmii_tx_if tx ();

  logic [7:0]  txd;
  logic        txen, txer, busy;
  logic [15:0] frame_cnt;
  logic [7:0]  err_cnt;

  eth_gmii_tx #(.IFG_BYTES(IFG), .MIN_PAYLOAD(MINP)) dut (
    .clk         (clk),
    .rst         (rst),
    .tx          (tx),
    .o_gmii_txd  (txd),
    .o_gmii_txen (txen),
    .o_gmii_txer (txer),
    .o_busy      (busy),
    .o_frame_cnt (frame_cnt),
    .o_err_cnt   (err_cnt)
  );

  logic        crc_init, crc_en;
  logic [7:0]  crc_data;
  logic [31:0] crc_val;

  eth_crc32_d8 u_crc (
    .clk  (clk),
    .rst  (rst),
    .init (crc_init),
    .en   (crc_en),
    .data (crc_data),
    .crc  (crc_val)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Monitor state, sampled on the falling edge.
  bq_t  cap;
  int   first_en, last_en, en_cnt, txer_cnt, txer_cyc, idle_cyc, c0;
  logic en_seen;

  task automatic clear_mon();
    cap = {};
    first_en = -1; last_en = -1; en_cnt = 0; txer_cnt = 0; txer_cyc = -1; idle_cyc = -1;
    en_seen = 1'b0;
  endtask

  task automatic monitor_loop();
    forever begin
      @(negedge clk);
      if (txen) begin
        if (!en_seen) first_en = cyc;
        en_seen = 1'b1;
        last_en = cyc;
        en_cnt++;
        cap.push_back(txd);
      end
      if (txer) begin
        txer_cnt++;
        txer_cyc = cyc;
      end
      if (en_seen && !busy && idle_cyc < 0) idle_cyc = cyc;
    end
  endtask

  function automatic logic [7:0] pat(input int seed, input int i);
    return 8'(seed * 37 + i * 11 + 5);
  endfunction

  // Bit-at-a-time reference CRC; returns the transmitted FCS value.
  function automatic logic [31:0] model_fcs(input bq_t b);
    logic [31:0] c;
    logic        fb;
    c = 32'hFFFFFFFF;
    foreach (b[i]) begin
      for (int k = 0; k < 8; k++) begin
        fb = c[0] ^ b[i][k];
        c  = c >> 1;
        if (fb) c = c ^ 32'hEDB88320;
      end
    end
    return ~c;
  endfunction

  function automatic bq_t build_exp(input int nbytes, input int seed);
    bq_t         e, body;
    logic [31:0] fcs;
    for (int i = 0; i < 7; i++) e.push_back(8'h55);
    e.push_back(8'hD5);
    for (int i = 0; i < nbytes; i++) body.push_back(pat(seed, i));
    while (body.size() < MINP) body.push_back(8'h00);
    fcs = model_fcs(body);
    foreach (body[i]) e.push_back(body[i]);
    for (int k = 0; k < 4; k++) e.push_back(fcs[8*k +: 8]);
    return e;
  endfunction

  task automatic send_word(input logic [31:0] d, input logic s, input logic e, input logic [1:0] m);
    int n;
    n = 0;
    tx.tx_data = d; tx.tx_sop = s; tx.tx_eop = e; tx.tx_mod = m; tx.tx_vld = 1'b1;
    while (!tx.tx_rdy && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("rdy_timeout", tx.tx_rdy, 1);
    if (s) c0 = cyc;
    @(negedge clk);
    tx.tx_vld = 1'b0;
  endtask

  task automatic send_frame(input int nwords, input int mod, input int seed,
                            input int stop_after, input int gap);
    logic [31:0] d;
    for (int w = 0; w < nwords; w++) begin
      for (int k = 0; k < 4; k++) d[31-8*k -: 8] = pat(seed, 4*w + k);
      if (stop_after != 0 && w == stop_after) repeat (gap) @(negedge clk);
      send_word(d, w == 0, w == nwords - 1, (w == nwords - 1) ? 2'(mod) : 2'd0);
    end
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while ((busy || idle_cyc < 0) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) check({tag, "_idle_timeout"}, busy, 0);
  endtask

  task automatic check_frame(input string tag, input int nbytes, input int seed, input int exp_en);
    bq_t e;
    int  nbad;
    e = build_exp(nbytes, seed);
    check({tag, "_txen_rise"}, first_en - c0, 1);
    check({tag, "_txen_cycles"}, en_cnt, exp_en);
    check({tag, "_txen_contig"}, last_en - first_en + 1, en_cnt);
    check({tag, "_len"}, cap.size(), e.size());
    nbad = 0;
    foreach (e[i]) if (i >= cap.size() || cap[i] !== e[i]) nbad++;
    check({tag, "_bad_bytes"}, nbad, 0);
    if (cap.size() >= 4)
      check({tag, "_fcs"}, {cap[cap.size()-1], cap[cap.size()-2], cap[cap.size()-3], cap[cap.size()-4]},
            {e[e.size()-1], e[e.size()-2], e[e.size()-3], e[e.size()-4]});
    check({tag, "_ifg"}, idle_cyc - last_en - 1, IFG);
    check({tag, "_txer"}, txer_cnt, 0);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_txd"}, txd, 0);
    check({tag, "_txen"}, txen, 0);
    check({tag, "_txer"}, txer, 0);
    check({tag, "_rdy"}, tx.tx_rdy, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_frame_cnt"}, frame_cnt, 0);
    check({tag, "_err_cnt"}, err_cnt, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bq_t         e;
    int          nbad;
    logic [31:0] d;

    tx.tx_data = '0; tx.tx_vld = 1'b0; tx.tx_sop = 1'b0; tx.tx_eop = 1'b0; tx.tx_mod = '0;
    crc_init = 1'b0; crc_en = 1'b0; crc_data = '0;
    c0 = 0;
    clear_mon();
    fork monitor_loop(); join_none

    repeat (3) @(negedge clk);
    check_reset_vals("rst");
    check("rst_crc", crc_val, 32'hFFFFFFFF);
    rst = 1'b0;
    #1 check("rst_release_rdy", tx.tx_rdy, 1);

    // CRC sub-module check value over "123456789".
    for (int i = 0; i < 9; i++) begin
      crc_data = 8'h31 + 8'(i);
      crc_en   = 1'b1;
      @(negedge clk);
    end
    crc_en = 1'b0;
    check("crc_check_value", ~crc_val, 32'hCBF43926);
    crc_init = 1'b1;
    @(negedge clk);
    crc_init = 1'b0;
    check("crc_reinit", crc_val, 32'hFFFFFFFF);

    // 64-byte frame, no padding.
    clear_mon();
    send_frame(16, 0, 1, 0, 0);
    wait_idle("a");
    check_frame("a", 64, 1, 76);
    check("a_frame_cnt", frame_cnt, 1);
    check("a_err_cnt", err_cnt, 0);

    // 10-byte frame padded to the minimum length.
    clear_mon();
    send_frame(3, 2, 2, 0, 0);
    wait_idle("b");
    check_frame("b", 10, 2, 72);
    check("b_frame_cnt", frame_cnt, 2);

    // Underrun after word 5; remaining words flushed through DROP.
    clear_mon();
    send_frame(16, 0, 3, 5, 20);
    wait_idle("c");
    e = build_exp(64, 3);
    nbad = 0;
    for (int i = 0; i < 28; i++) if (i >= cap.size() || cap[i] !== e[i]) nbad++;
    check("c_bad_prefix", nbad, 0);
    check("c_txer_cnt", txer_cnt, 1);
    check("c_txer_cycle", txer_cyc - c0, 29);
    check("c_txen_cycles", en_cnt, 29);
    check("c_txen_last", last_en - c0, 29);
    check("c_err_cnt", err_cnt, 1);
    check("c_frame_cnt", frame_cnt, 2);

    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_reset_vals("rst2");
    rst = 1'b0;

    // Orphan words in IDLE.
    clear_mon();
    #1 check("d_idle_rdy", tx.tx_rdy, 1);
    send_word(32'hDEADBEEF, 1'b0, 1'b0, 2'd0);
    check("d_err_one", err_cnt, 1);
    check("d_busy", busy, 0);
    for (int i = 0; i < 299; i++) send_word(32'(i), 1'b0, (i % 3) == 0, 2'd0);
    check("d_err_sat", err_cnt, 255);
    check("d_no_txen", en_seen, 0);

    // Reset in the middle of DATA.
    clear_mon();
    for (int w = 0; w < 3; w++) begin
      for (int k = 0; k < 4; k++) d[31-8*k -: 8] = pat(4, 4*w + k);
      send_word(d, w == 0, 1'b0, 2'd0);
    end
    check("e_txen_mid", txen, 1);
    rst = 1'b1;
    @(negedge clk);
    check_reset_vals("e_rst");
    @(negedge clk);
    rst = 1'b0;
    #1 check("e_release_rdy", tx.tx_rdy, 1);

    // Frame after mid-frame reset.
    clear_mon();
    send_frame(3, 2, 5, 0, 0);
    wait_idle("f");
    check_frame("f", 10, 5, 72);
    check("f_frame_cnt", frame_cnt, 1);
    check("f_err_cnt", err_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
